// File: rtl/addr_gen_2d.sv
// Two-level strided index generator feeding a valid/ready FIFO: emits cnt_in x cnt_out
// indices per descriptor with last_o, then a done_o pulse. Optional macro ADDR_GEN_WRAP_EN.
module addr_gen_2d #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    parameter int BUF_DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  nreset_i,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [ADDR_WIDTH-1:0] cfg_stride_in,
    input  logic [ADDR_WIDTH-1:0] cfg_stride_out,
    input  logic [CNT_WIDTH-1:0]  cfg_cnt_in,
    input  logic [CNT_WIDTH-1:0]  cfg_cnt_out,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  addr_o_valid,
    input  logic                  addr_o_ready,
    output logic                  last_o,
    output logic                  done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The circular-buffer modulus must be a power of two so it reduces to a bit mask.
    generate
        if ((BUF_DEPTH < 1) || ((BUF_DEPTH & (BUF_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("addr_gen_2d: BUF_DEPTH must be a power of 2");
        end
    endgenerate

`ifdef ADDR_GEN_WRAP_EN
    localparam logic [ADDR_WIDTH-1:0] WRAP_MASK = ADDR_WIDTH'(BUF_DEPTH - 1);
`endif

    function automatic logic [ADDR_WIDTH-1:0] wrap_addr(input logic [ADDR_WIDTH-1:0] a);
`ifdef ADDR_GEN_WRAP_EN
        wrap_addr = a & WRAP_MASK;
`else
        wrap_addr = a;
`endif
    endfunction

    state_t                state_r,      state_s;
    logic [ADDR_WIDTH-1:0] addr_r,       addr_s;
    logic [ADDR_WIDTH-1:0] row_base_r,   row_base_s;
    logic [ADDR_WIDTH-1:0] stride_in_r,  stride_in_s;
    logic [ADDR_WIDTH-1:0] stride_out_r, stride_out_s;
    logic [CNT_WIDTH-1:0]  cnt_in_r,     cnt_in_s;
    logic [CNT_WIDTH-1:0]  cnt_out_r,    cnt_out_s;
    logic [CNT_WIDTH-1:0]  i_r,          i_s;
    logic [CNT_WIDTH-1:0]  j_r,          j_s;
    logic                  valid_r,      valid_s;
    logic                  last_r,       last_s;
    logic                  ready_r,      ready_s;
    logic                  done_r,       done_s;

    logic [CNT_WIDTH-1:0]  i_last_s;
    logic [CNT_WIDTH-1:0]  j_last_s;

    // Terminal index values; only meaningful in RUN where both counts are non-zero.
    always_comb begin
        i_last_s = cnt_in_r - CNT_WIDTH'(1);
        j_last_s = cnt_out_r - CNT_WIDTH'(1);
    end

    // Next-state and next-output computation for the descriptor sequencer.
    always_comb begin
        state_s      = state_r;
        addr_s       = addr_r;
        row_base_s   = row_base_r;
        stride_in_s  = stride_in_r;
        stride_out_s = stride_out_r;
        cnt_in_s     = cnt_in_r;
        cnt_out_s    = cnt_out_r;
        i_s          = i_r;
        j_s          = j_r;
        valid_s      = valid_r;
        last_s       = last_r;
        ready_s      = ready_r;
        done_s       = 1'b0;

        case (state_r)
            IDLE: begin
                ready_s = 1'b1;
                valid_s = 1'b0;
                if (cfg_valid) begin
                    stride_in_s  = cfg_stride_in;
                    stride_out_s = cfg_stride_out;
                    cnt_in_s     = cfg_cnt_in;
                    cnt_out_s    = cfg_cnt_out;
                    i_s          = '0;
                    j_s          = '0;
                    ready_s      = 1'b0;
                    if ((cfg_cnt_in == '0) || (cfg_cnt_out == '0)) begin
                        state_s = DONE;
                        done_s  = 1'b1;
                        last_s  = 1'b0;
                    end else begin
                        state_s    = RUN;
                        addr_s     = wrap_addr(cfg_base);
                        row_base_s = wrap_addr(cfg_base);
                        valid_s    = 1'b1;
                        last_s     = (cfg_cnt_in == CNT_WIDTH'(1)) && (cfg_cnt_out == CNT_WIDTH'(1));
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                ready_s = 1'b0;
                if (addr_o_ready) begin
                    if (i_r != i_last_s) begin
                        i_s    = i_r + CNT_WIDTH'(1);
                        addr_s = wrap_addr(addr_r + stride_in_r);
                        last_s = ((i_r + CNT_WIDTH'(1)) == i_last_s) && (j_r == j_last_s);
                    end else if (j_r != j_last_s) begin
                        i_s        = '0;
                        j_s        = j_r + CNT_WIDTH'(1);
                        row_base_s = wrap_addr(row_base_r + stride_out_r);
                        addr_s     = wrap_addr(row_base_r + stride_out_r);
                        last_s     = (cnt_in_r == CNT_WIDTH'(1)) && ((j_r + CNT_WIDTH'(1)) == j_last_s);
                    end else begin
                        state_s = DONE;
                        valid_s = 1'b0;
                        last_s  = 1'b0;
                        done_s  = 1'b1;
                    end
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                state_s = IDLE;
                ready_s = 1'b1;
                valid_s = 1'b0;
            end
            default: begin
                state_s = IDLE;
                ready_s = 1'b1;
                valid_s = 1'b0;
                last_s  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any descriptor in flight.
    always_ff @(posedge clk or negedge nreset_i) begin
        if (!nreset_i) begin
            state_r      <= IDLE;
            addr_r       <= '0;
            row_base_r   <= '0;
            stride_in_r  <= '0;
            stride_out_r <= '0;
            cnt_in_r     <= '0;
            cnt_out_r    <= '0;
            i_r          <= '0;
            j_r          <= '0;
            valid_r      <= 1'b0;
            last_r       <= 1'b0;
            ready_r      <= 1'b1;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            addr_r       <= addr_s;
            row_base_r   <= row_base_s;
            stride_in_r  <= stride_in_s;
            stride_out_r <= stride_out_s;
            cnt_in_r     <= cnt_in_s;
            cnt_out_r    <= cnt_out_s;
            i_r          <= i_s;
            j_r          <= j_s;
            valid_r      <= valid_s;
            last_r       <= last_s;
            ready_r      <= ready_s;
            done_r       <= done_s;
        end
    end

    assign cfg_ready    = ready_r;
    assign addr_o       = addr_r;
    assign addr_o_valid = valid_r;
    assign last_o       = last_r;
    assign done_o       = done_r;

endmodule

// File: tb/tb_addr_gen_2d.sv
// Directed bench for addr_gen_2d: descriptor table with expected streams and ready
// patterns, plus hand-written reset-mid-run and held-cfg_valid sequences.
module tb_addr_gen_2d;

    logic        clk = 1'b0;
    logic        nreset_i;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_base;
    logic [31:0] cfg_stride_in;
    logic [31:0] cfg_stride_out;
    logic [15:0] cfg_cnt_in;
    logic [15:0] cfg_cnt_out;
    logic [31:0] addr_o;
    logic        addr_o_valid;
    logic        addr_o_ready;
    logic        last_o;
    logic        done_o;

    int passed = 0;
    int total  = 0;

    addr_gen_2d dut (
        .clk            (clk),
        .nreset_i       (nreset_i),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_base       (cfg_base),
        .cfg_stride_in  (cfg_stride_in),
        .cfg_stride_out (cfg_stride_out),
        .cfg_cnt_in     (cfg_cnt_in),
        .cfg_cnt_out    (cfg_cnt_out),
        .addr_o         (addr_o),
        .addr_o_valid   (addr_o_valid),
        .addr_o_ready   (addr_o_ready),
        .last_o         (last_o),
        .done_o         (done_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]      base;
        logic [31:0]      sin;
        logic [31:0]      sout;
        logic [15:0]      cin;
        logic [15:0]      cout;
        logic [15:0]      rdy;   // bit c = addr_o_ready in stream cycle c; 1 after cycle 15
        logic [3:0]       n;
        logic [7:0][31:0] exp;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vec [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    task automatic set_vec(input int k, input logic [31:0] base, input logic [31:0] sin,
                           input logic [31:0] sout, input logic [15:0] cin, input logic [15:0] cout,
                           input logic [15:0] rdy, input logic [3:0] n,
                           input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                           input logic [31:0] e3, input logic [31:0] e4, input logic [31:0] e5);
        vec[k].base = base; vec[k].sin = sin; vec[k].sout = sout;
        vec[k].cin = cin; vec[k].cout = cout; vec[k].rdy = rdy; vec[k].n = n;
        vec[k].exp[0] = e0; vec[k].exp[1] = e1; vec[k].exp[2] = e2;
        vec[k].exp[3] = e3; vec[k].exp[4] = e4; vec[k].exp[5] = e5;
        vec[k].exp[6] = 32'h0; vec[k].exp[7] = 32'h0;
    endtask

    task automatic run_desc(input int k);
        int  n;
        bit  done_seen;
        bit  stall;
        logic [31:0] held_a;
        logic        held_l;
        @(negedge clk);
        chk("cfg_ready_idle", {31'd0, cfg_ready}, 32'd1);
        cfg_base       = vec[k].base;
        cfg_stride_in  = vec[k].sin;
        cfg_stride_out = vec[k].sout;
        cfg_cnt_in     = vec[k].cin;
        cfg_cnt_out    = vec[k].cout;
        cfg_valid      = 1'b1;
        addr_o_ready   = 1'b0;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("first_valid", {31'd0, addr_o_valid}, {31'd0, (vec[k].n != 4'd0)});
        chk("first_done",  {31'd0, done_o},       {31'd0, (vec[k].n == 4'd0)});
        n = 0; stall = 1'b0; done_seen = done_o; held_a = '0; held_l = 1'b0;
        for (int c = 0; c < 64 && !done_seen; c++) begin
            addr_o_ready = (c < 16) ? vec[k].rdy[c] : 1'b1;
            #1;
            if (stall) begin
                chk("valid_held", {31'd0, addr_o_valid}, 32'd1);
                chk("addr_held", addr_o, held_a);
                chk("last_held", {31'd0, last_o}, {31'd0, held_l});
            end
            if (addr_o_valid && addr_o_ready) begin
                if (n < 8) chk("addr", addr_o, vec[k].exp[n]);
                chk("last", {31'd0, last_o}, {31'd0, (n == int'(vec[k].n) - 1)});
                n++;
                stall = 1'b0;
            end else if (addr_o_valid) begin
                stall  = 1'b1;
                held_a = addr_o;
                held_l = last_o;
            end else begin
                stall = 1'b0;
            end
            @(negedge clk);
            if (done_o) begin
                done_seen = 1'b1;
                chk("valid_low_at_done", {31'd0, addr_o_valid}, 32'd0);
            end
        end
        chk("xfer_count", n, {28'd0, vec[k].n});
        chk("done_seen", {31'd0, done_seen}, 32'd1);
        addr_o_ready = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done_o}, 32'd0);
        chk("cfg_ready_after", {31'd0, cfg_ready}, 32'd1);
    endtask

    initial begin
        nreset_i = 1'b0; cfg_valid = 1'b0; addr_o_ready = 1'b0;
        cfg_base = '0; cfg_stride_in = '0; cfg_stride_out = '0; cfg_cnt_in = '0; cfg_cnt_out = '0;

        set_vec(0, 32'h10, 32'h1, 32'h0, 16'd4, 16'd1, 16'hFFFF, 4'd4,
                32'h10, 32'h11, 32'h12, 32'h13, 32'h0, 32'h0);
`ifdef ADDR_GEN_WRAP_EN
        set_vec(1, 32'h0, 32'h4, 32'h100, 16'd3, 16'd2, 16'hFFFF, 4'd6,
                32'h0, 32'h4, 32'h8, 32'h0, 32'h4, 32'h8);
`else
        set_vec(1, 32'h0, 32'h4, 32'h100, 16'd3, 16'd2, 16'hFFFF, 4'd6,
                32'h0, 32'h4, 32'h8, 32'h100, 32'h104, 32'h108);
`endif
        set_vec(2, 32'h10, 32'h1, 32'h0, 16'd4, 16'd1, 16'h0069, 4'd4,
                32'h10, 32'h11, 32'h12, 32'h13, 32'h0, 32'h0);
        set_vec(3, 32'h30, 32'h1, 32'h0, 16'd5, 16'd0, 16'hFFFF, 4'd0,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
`ifdef ADDR_GEN_WRAP_EN
        set_vec(4, 32'hFFFFFFFE, 32'h1, 32'h0, 16'd4, 16'd1, 16'hFFFF, 4'd4,
                32'hFE, 32'hFF, 32'h0, 32'h1, 32'h0, 32'h0);
`else
        set_vec(4, 32'hFFFFFFFE, 32'h1, 32'h0, 16'd4, 16'd1, 16'hFFFF, 4'd4,
                32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h0, 32'h0);
`endif
        set_vec(5, 32'h20, 32'hFFFFFFFF, 32'hFFFFFFF0, 16'd2, 16'd2, 16'hFFFF, 4'd4,
                32'h20, 32'h1F, 32'h10, 32'h0F, 32'h0, 32'h0);
        set_vec(6, 32'h55, 32'h7, 32'h9, 16'd1, 16'd1, 16'hFFFF, 4'd1,
                32'h55, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        set_vec(7, 32'h40, 32'h1, 32'h1, 16'd0, 16'd3, 16'hFFFF, 4'd0,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        set_vec(8, 32'h4, 32'h1, 32'h8, 16'd1, 16'd3, 16'hAAAA, 4'd3,
                32'h4, 32'hC, 32'h14, 32'h0, 32'h0, 32'h0);

        // Reset state
        #12;
        chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        chk("rst_valid", {31'd0, addr_o_valid}, 32'd0);
        chk("rst_addr", addr_o, 32'd0);
        chk("rst_last", {31'd0, last_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        @(negedge clk);
        nreset_i = 1'b1;

        for (int k = 0; k < NVEC; k++) run_desc(k);

        // Reset in the middle of a 10-address descriptor
        @(negedge clk);
        cfg_base = 32'h20; cfg_stride_in = 32'h2; cfg_stride_out = 32'h0;
        cfg_cnt_in = 16'd10; cfg_cnt_out = 16'd1; cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0; addr_o_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_addr", addr_o, 32'h24);
        #2 nreset_i = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, addr_o_valid}, 32'd0);
        chk("midrst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        chk("midrst_addr", addr_o, 32'd0);
        chk("midrst_done", {31'd0, done_o}, 32'd0);
        @(negedge clk);
        nreset_i = 1'b1;
        addr_o_ready = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("no_done_after_rst", {31'd0, done_o}, 32'd0);
        end
        run_desc(0);

        // cfg_valid held through RUN: second descriptor only taken after DONE
        @(negedge clk);
        cfg_base = 32'h40; cfg_stride_in = 32'h1; cfg_stride_out = 32'h0;
        cfg_cnt_in = 16'd2; cfg_cnt_out = 16'd1; cfg_valid = 1'b1; addr_o_ready = 1'b1;
        @(negedge clk);
        cfg_base = 32'h80; cfg_cnt_in = 16'd1;
        chk("hold_a0", addr_o, 32'h40);
        chk("hold_busy0", {31'd0, cfg_ready}, 32'd0);
        @(negedge clk);
        chk("hold_a1", addr_o, 32'h41);
        chk("hold_a1_last", {31'd0, last_o}, 32'd1);
        @(negedge clk);
        chk("hold_done", {31'd0, done_o}, 32'd1);
        chk("hold_busy_done", {31'd0, cfg_ready}, 32'd0);
        @(negedge clk);
        chk("hold_ready_again", {31'd0, cfg_ready}, 32'd1);
        chk("hold_no_valid", {31'd0, addr_o_valid}, 32'd0);
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("hold_b_valid", {31'd0, addr_o_valid}, 32'd1);
        chk("hold_b_addr", addr_o, 32'h80);
        chk("hold_b_last", {31'd0, last_o}, 32'd1);
        @(negedge clk);
        chk("hold_b_done", {31'd0, done_o}, 32'd1);
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
